// File: rtl/id_stage_pipe.sv
// Decode stage: register file with write-through bypass, early branch/jump
// resolution, load-use / branch-operand hazard stalls and the ID/EX register.
module id_stage_pipe #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int CTRL_W    = 14,
  parameter int REGWR_BIT = 13,
  parameter int MEMRD_BIT = 12,
  localparam int AW       = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_pc4,
  input  logic [31:0]       if_ins,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              id_ready,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [AW-1:0]     mem_rd,
  input  logic              mem_we,
  input  logic              mem_is_load,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_data1,
  output logic [XLEN-1:0]   ex_data2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc4,
  output logic [AW-1:0]     ex_rs,
  output logic [AW-1:0]     ex_rt,
  output logic [AW-1:0]     ex_rd,
  output logic [1:0]        pc_src,
  output logic [XLEN-1:0]   branch_target,
  output logic [XLEN-1:0]   jump_target,
  output logic              flush_if
);

  logic [XLEN-1:0] regs [NREG];
  logic            ex_rtype;

  logic [5:0]      op;
  logic [AW-1:0]   rs, rt, rd, ex_dest;
  logic [XLEN-1:0] imm, rd1, rd2, br1, br2;
  logic            is_rtype, is_br, is_j;
  logic            haz_a, haz_b, haz_c, haz, resolve, issue;

  assign op       = if_ins[31:26];
  assign rs       = if_ins[21 +: AW];
  assign rt       = if_ins[16 +: AW];
  assign rd       = if_ins[11 +: AW];
  assign imm      = {{(XLEN-16){if_ins[15]}}, if_ins[15:0]};
  assign is_rtype = (op == 6'h00);
  assign is_br    = (op == 6'h04) || (op == 6'h05);
  assign is_j     = (op == 6'h02) || (op == 6'h03);

  // Write-through: a same-cycle write-back is visible to the read ports.
  assign rd1 = (rs == '0) ? '0 : (wb_we && wb_addr == rs) ? wb_data : regs[rs];
  assign rd2 = (rt == '0) ? '0 : (wb_we && wb_addr == rt) ? wb_data : regs[rt];

  // Branch compare may take an ALU result waiting in EX/MEM; loads are not ready yet.
  assign br1 = (mem_we && !mem_is_load && rs != '0 && mem_rd == rs) ? mem_data : rd1;
  assign br2 = (mem_we && !mem_is_load && rt != '0 && mem_rd == rt) ? mem_data : rd2;

  assign ex_dest = ex_rtype ? ex_rd : ex_rt;
  assign haz_a = ex_valid && ex_ctrl[MEMRD_BIT] && ex_rt != '0 && (ex_rt == rs || ex_rt == rt);
  assign haz_b = is_br && ex_valid && ex_ctrl[REGWR_BIT] && ex_dest != '0 &&
                 (ex_dest == rs || ex_dest == rt);
  assign haz_c = is_br && mem_is_load && mem_we && mem_rd != '0 && (mem_rd == rs || mem_rd == rt);
  assign haz   = if_valid && (haz_a || haz_b || haz_c);

  assign resolve = !reset && if_valid && !haz && !ex_stall && !flush;
  assign issue   = resolve;

  assign branch_target = if_pc4 + (imm << 2);
  assign jump_target   = {if_pc4[XLEN-1:28], if_ins[25:0], 2'b00};

  always_comb begin
    pc_src = 2'b00;
    if (resolve) begin
      if (is_j)
        pc_src = 2'b10;
      else if ((op == 6'h04 && br1 == br2) || (op == 6'h05 && br1 != br2))
        pc_src = 2'b01;
    end
  end

  assign flush_if = (pc_src != 2'b00);

  always_comb begin
    id_ready = 1'b1;
    if (!reset) begin
      if (ex_stall)   id_ready = 1'b0;
      else if (flush) id_ready = 1'b1;
      else if (haz)   id_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Bubbles clear the whole ID/EX word so nothing downstream can write.
  always_ff @(posedge clk) begin
    if (reset || (!ex_stall && !issue)) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_data1 <= '0;
      ex_data2 <= '0;
      ex_imm   <= '0;
      ex_pc4   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_rtype <= 1'b0;
    end else if (issue) begin
      ex_valid <= 1'b1;
      ex_ctrl  <= ctrl_in;
      ex_data1 <= rd1;
      ex_data2 <= rd2;
      ex_imm   <= imm;
      ex_pc4   <= if_pc4;
      ex_rs    <= rs;
      ex_rt    <= rt;
      ex_rd    <= rd;
      ex_rtype <= is_rtype;
    end
  end

endmodule
